// File: rtl/ntt_masked_modq_add_sub_pipe.sv
// First-order masked (u +/- v) mod Q on arithmetic shares, LANES lanes, fixed latency LAT = WIDTH+7.
// Free-running pipeline: one operation per clock, no stall or back-pressure; zeroize/reset drop everything in flight.
package ntt_mldsa_pkg;
    localparam longint unsigned MLDSA_Q = 64'd8380417;
endpackage

module ntt_masked_modq_add_sub_pipe
    import ntt_mldsa_pkg::*;
#(
    parameter int              WIDTH = 46,
    parameter longint unsigned Q     = MLDSA_Q,
    parameter int              LANES = 1,
    parameter int              TAG_W = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              zeroize,
    input  logic                              valid_i,
    input  logic                              sub_i,
    input  logic [TAG_W-1:0]                  tag_i,
    input  logic [LANES-1:0][1:0][WIDTH-1:0]  u_i,
    input  logic [LANES-1:0][1:0][WIDTH-1:0]  v_i,
    input  logic [LANES-1:0][3:0][WIDTH-1:0]  rnd_i,
    output logic                              valid_o,
    output logic [TAG_W-1:0]                  tag_o,
    output logic [LANES-1:0][1:0][WIDTH-1:0]  res_o,
    output logic                              busy_o
);
    localparam int K    = $clog2(Q);
    localparam int LAT  = WIDTH + 7;
    localparam int SDLY = WIDTH + 5;

    typedef logic [WIDTH-1:0] word_t;

    localparam word_t Q_W    = word_t'(Q);
    localparam word_t NEG_Q  = word_t'(0) - Q_W;
    localparam word_t ROLLER = word_t'((64'd1 << K) - Q);

    logic clr;
    assign clr = !reset_n || zeroize;

    logic [LAT-1:0]   vld_sr;
    logic [TAG_W-1:0] tag_sr [LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_sr  <= '0;
            tag_sr  <= '{default: '0};
            valid_o <= 1'b0;
            tag_o   <= '0;
            busy_o  <= 1'b0;
        end else begin
            vld_sr    <= {vld_sr[LAT-2:0], valid_i};
            tag_sr[0] <= tag_i;
            for (int i = 1; i < LAT; i++) tag_sr[i] <= tag_sr[i-1];
            valid_o   <= vld_sr[LAT-1];
            tag_o     <= tag_sr[LAT-1];
            // next-state OR, so busy_o covers the valid_o cycle itself
            busy_o    <= valid_i | (|vld_sr);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        word_t vp [2];
        word_t u_q [2];
        word_t vp_q [2];
        word_t s_q [2];
        word_t sd0 [SDLY];
        word_t sd1 [SDLY];
        word_t a [WIDTH];
        word_t b [WIDTH];
        logic  c0 [WIDTH+1];
        logic  c1 [WIDTH+1];
        word_t z0 [WIDTH+1];
        word_t z1 [WIDTH+1];
        word_t bz0, bz1, kv0, kv1, p0, p1, rr, cs0, cs1, res0, res1;
        logic  kd;

        always_comb begin
            vp[0] = v_i[l][0];
            vp[1] = v_i[l][1];
            if (sub_i) begin
                vp[0] = Q_W - v_i[l][0];
                vp[1] = word_t'(0) - v_i[l][1];
            end
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                u_q  <= '{default: '0};
                vp_q <= '{default: '0};
                s_q  <= '{default: '0};
                sd0  <= '{default: '0};
                sd1  <= '{default: '0};
                a    <= '{default: '0};
                b    <= '{default: '0};
                c0   <= '{default: 1'b0};
                c1   <= '{default: 1'b0};
                z0   <= '{default: '0};
                z1   <= '{default: '0};
                bz0  <= '0;  bz1 <= '0;
                kv0  <= '0;  kv1 <= '0;
                p0   <= '0;  p1  <= '0;  rr <= '0;  kd <= 1'b0;
                cs0  <= '0;  cs1 <= '0;
                res0 <= '0;  res1 <= '0;
            end else begin
                u_q  <= '{u_i[l][0], u_i[l][1]};
                vp_q <= vp;
                s_q[0] <= u_q[0] + vp_q[0];
                s_q[1] <= u_q[1] + vp_q[1];

                sd0[0] <= s_q[0];
                sd1[0] <= s_q[1];
                for (int i = 1; i < SDLY; i++) begin
                    sd0[i] <= sd0[i-1];
                    sd1[i] <= sd1[i-1];
                end

                // A2B: share 0 owns operand a, share 1 owns operand b; masked ripple carry, one bit per stage
                a[0]  <= s_q[0] + ROLLER;
                b[0]  <= s_q[1];
                c0[0] <= 1'b0;
                c1[0] <= 1'b0;
                z0[0] <= '0;
                z1[0] <= '0;
                for (int i = 0; i < WIDTH; i++) begin
                    z0[i+1] <= z0[i] | (word_t'(a[i][i] ^ c0[i]) << i);
                    z1[i+1] <= z1[i] | (word_t'(b[i][i] ^ c1[i]) << i);
                    c0[i+1] <= (a[i][i] & b[i][i] ^ rnd_i[l][1][i])
                             ^ (c0[i] & a[i][i]) ^ ((c0[i] & b[i][i]) ^ rnd_i[l][2][i]);
                    c1[i+1] <= rnd_i[l][1][i]
                             ^ (c1[i] & b[i][i]) ^ ((c1[i] & a[i][i]) ^ rnd_i[l][2][i]);
                end
                for (int i = 0; i < WIDTH - 1; i++) begin
                    a[i+1] <= a[i];
                    b[i+1] <= b[i];
                end
                bz0 <= z0[WIDTH] ^ rnd_i[l][3];
                bz1 <= z1[WIDTH] ^ rnd_i[l][3];

                kv0 <= (bz0 >> K) & word_t'(1);
                kv1 <= (bz1 >> K) & word_t'(1);

                // B2A of one bit: share 1 offers both masked candidates, share 0 picks one
                rr  <= rnd_i[l][0];
                p0  <= kv1 - rnd_i[l][0];
                p1  <= (kv1 ^ word_t'(1)) - rnd_i[l][0];
                kd  <= (kv0 == word_t'(1));
                cs0 <= kd ? p1 : p0;
                cs1 <= rr;

                res0 <= sd0[SDLY-1] + cs0 * NEG_Q;
                res1 <= sd1[SDLY-1] + cs1 * NEG_Q;
            end
        end

        assign res_o[l][0] = res0;
        assign res_o[l][1] = res1;
    end
endmodule

// File: tb/tb_ntt_masked_modq_add_sub_pipe.sv
// Bench: queue-based reference model of (u +/- v) mod Q with per-cycle output/busy checks,
// plus literal wrap-boundary vectors, zeroize/reset drops and a share-bit bias check.
module tb_ntt_masked_modq_add_sub_pipe;
    localparam int W = 46, L = 4, TW = 8, LAT = W + 7;
    localparam longint unsigned QQ = 64'd8380417;
    typedef logic [W-1:0] word_t;
    typedef logic [L-1:0][W-1:0] lanes_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0, zeroize = 1'b0, valid_i = 1'b0, sub_i = 1'b0;
    logic valid_o, busy_o;
    logic [TW-1:0] tag_i = '0, tag_o;
    logic [L-1:0][1:0][W-1:0] u_i = '0, v_i = '0, res_o;
    logic [L-1:0][3:0][W-1:0] rnd_i = '0;

    always #5 clk = ~clk;

    ntt_masked_modq_add_sub_pipe #(.WIDTH(W), .LANES(L), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .valid_i(valid_i), .sub_i(sub_i),
        .tag_i(tag_i), .u_i(u_i), .v_i(v_i), .rnd_i(rnd_i),
        .valid_o(valid_o), .tag_o(tag_o), .res_o(res_o), .busy_o(busy_o));

    typedef struct { int due; logic [TW-1:0] tag; lanes_t val; } exp_t;
    exp_t exp_q[$];
    int  cyc = 0, n_cmp = 0, n_err = 0;
    bit  clr_seen = 0, live = 0, mask_phase = 0;
    int  ones [2][W];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: expected result of every accepted operation, due LAT edges later
    always @(posedge clk) begin
        exp_t e;
        word_t uu, vv;
        cyc++;
        clr_seen = !reset_n || zeroize;
        if (clr_seen) begin
            exp_q.delete();
            live = 1;
        end else if (valid_i) begin
            e.due = cyc + LAT;
            e.tag = tag_i;
            for (int l = 0; l < L; l++) begin
                uu = u_i[l][0] + u_i[l][1];
                vv = v_i[l][0] + v_i[l][1];
                if (sub_i) e.val[l] = word_t'((64'(uu) + QQ - 64'(vv)) % QQ);
                else       e.val[l] = word_t'((64'(uu) + 64'(vv)) % QQ);
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy_o", busy_o, exp_q.size() != 0);
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                chk("valid_o", valid_o, 1);
                chk("tag_o", tag_o, exp_q[0].tag);
                for (int l = 0; l < L; l++)
                    chk("lane_sum", word_t'(res_o[l][0] + res_o[l][1]), exp_q[0].val[l]);
                if (mask_phase)
                    for (int j = 0; j < 2; j++)
                        for (int k = 0; k < W; k++) ones[j][k] += int'(res_o[0][j][k]);
                void'(exp_q.pop_front());
            end else begin
                chk("valid_o_idle", valid_o, 0);
            end
            if (clr_seen) begin
                chk("res_o_cleared", |res_o, 0);
                chk("tag_o_cleared", tag_o, 0);
            end
        end
    end

    function automatic word_t rnd_word();
        return word_t'({$urandom, $urandom});
    endfunction

    function automatic lanes_t pk(word_t a0, word_t a1, word_t a2, word_t a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int l = 0; l < L; l++)
            for (int j = 0; j < 4; j++) rnd_i[l][j] = rnd_word();
    endtask

    task automatic set_lane(int l, word_t u, word_t v);
        word_t r;
        r = rnd_word(); u_i[l][0] = r; u_i[l][1] = u - r;
        r = rnd_word(); v_i[l][0] = r; v_i[l][1] = v - r;
    endtask

    task automatic lit_op(string name, bit sub, logic [TW-1:0] tag, lanes_t u, lanes_t v, lanes_t e);
        int lat;
        valid_i = 1'b1; sub_i = sub; tag_i = tag;
        for (int l = 0; l < L; l++) set_lane(l, u[l], v[l]);
        step();
        valid_i = 1'b0;
        lat = 0;
        while (lat < 63) begin
            step();
            lat++;
            if (valid_o === 1'b1) break;
        end
        chk({name, "_latency"}, lat, 53);
        chk({name, "_tag"}, tag_o, tag);
        for (int l = 0; l < L; l++)
            chk({name, "_value"}, word_t'(res_o[l][0] + res_o[l][1]), e[l]);
    endtask

    task automatic burst(int n);
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b1; sub_i = 1'($urandom); tag_i = TW'(i);
            for (int l = 0; l < L; l++)
                set_lane(l, word_t'($urandom_range(32'(QQ - 1))), word_t'($urandom_range(32'(QQ - 1))));
            step();
        end
        valid_i = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        lit_op("add_wrap", 1'b0, 8'h5A,
               pk(5, word_t'(QQ - 1), word_t'(QQ - 1), 0), pk(7, 1, word_t'(QQ - 1), 0),
               pk(12, 0, 8380415, 0));
        lit_op("sub_wrap", 1'b1, 8'hC3,
               pk(3, 0, word_t'(QQ - 1), 0), pk(5, 0, 0, word_t'(QQ - 1)),
               pk(8380415, 0, 8380416, 1));

        burst(100);
        repeat (LAT + 3) step();
        chk("b2b_drain", exp_q.size(), 0);

        burst(10);
        repeat (20) step();
        zeroize = 1'b1; valid_i = 1'b1; tag_i = 8'hEE;
        step();
        zeroize = 1'b0; valid_i = 1'b0;
        chk("zeroize_busy", busy_o, 0);
        chk("zeroize_res", |res_o, 0);
        lit_op("post_zeroize", 1'b0, 8'h11, pk(100, 1, 2, 3), pk(200, 4, 5, 6), pk(300, 5, 7, 9));

        burst(10);
        repeat (15) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("reset_valid", valid_o, 0);
        chk("reset_res", |res_o, 0);
        lit_op("post_reset", 1'b1, 8'h22, pk(10, 0, 1, 7), pk(4, 1, 1, 9), pk(6, 8380416, 0, 8380415));

        mask_phase = 1;
        for (int i = 0; i < 10000; i++) begin
            valid_i = 1'b1; sub_i = 1'b0; tag_i = TW'(i);
            for (int l = 0; l < L; l++) set_lane(l, 1234567, 7654321);
            step();
        end
        valid_i = 1'b0;
        repeat (LAT + 3) step();
        mask_phase = 0;
        chk("mask_drain", exp_q.size(), 0);
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < W; k++) begin
                cnt = ones[j][k];
                n_cmp++;
                if (cnt < 4800 || cnt > 5200) begin
                    n_err++;
                    $display("FAIL share_bias: share %0d bit %0d has %0d ones of 10000, expected 4800..5200", j, k, cnt);
                end
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end
endmodule
